seq_detector_param: RTL and testbench

//   Parametrised serial bit-pattern detector; successor to the fixed single-pattern FSM.

---
 rtl/seq_det_pkg.sv | 11 +
 rtl/sat_counter.sv | 20 ++
 rtl/seq_detector_param.sv | 54 +++++
 tb/tb_seq_detector_param.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared defaults and sizing helper for the serial pattern detector
package seq_det_pkg;
  localparam int DEF_LEN = 4;
  localparam logic [DEF_LEN-1:0] DEF_PATTERN = 4'b1011;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic         o_sat
);
  logic [W-1:0] r_cnt;
  assign o_cnt = r_cnt;
  assign o_sat = &r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && !o_sat) r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial LEN-bit pattern detector with fill gating,
// optional overlap, input qualification and a saturating match counter
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = DEF_PATTERN,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_in_valid,
  input  logic             i_in,
  output logic             o_out,
  output logic [CNT_W-1:0] o_match_cnt,
  output logic             o_cnt_sat
);
  localparam int FW = clog2(LEN + 1);
  logic [LEN-1:0] r_hist;
  logic [FW-1:0]  r_fill;
  logic           r_out;
  logic [LEN-1:0] w_nxt;
  logic           w_match;
  assign w_nxt   = {r_hist[LEN-2:0], i_in};
  // fill gating keeps the zeroed history from faking a match
  assign w_match = i_in_valid & ~i_clear & (w_nxt == PATTERN) & (r_fill >= FW'(LEN - 1));
  assign o_out   = r_out;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
    end else begin
      r_out <= w_match;
      if (i_clear) begin
        r_hist <= '0;
        r_fill <= '0;
      end else if (i_in_valid) begin
        r_hist <= w_nxt;
        r_fill <= (w_match && !OVERLAP) ? '0 : (r_fill == FW'(LEN)) ? r_fill : r_fill + 1'b1;
      end
    end
  end
  sat_counter #(.W(CNT_W)) u_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_clear),
    .i_inc   (w_match),
    .o_cnt   (o_match_cnt),
    .o_sat   (o_cnt_sat)
  );
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: four detector configurations, each fed only when its
// in_valid bit is set; expected pulses go to a scoreboard checked by a monitor
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       in = 1'b0;
  logic [3:0] vld = '0;
  logic [3:0] o_out;
  logic [3:0] sat;
  logic [7:0] c0, c1, c2;
  logic [1:0] c3;
  int cyc = 0;
  int checks = 0;
  int failures = 0;
  typedef struct {int d; int cyc; int cnt;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_detector_param u_d0 (.i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_in_valid(vld[0]),
    .i_in(in), .o_out(o_out[0]), .o_match_cnt(c0), .o_cnt_sat(sat[0]));
  seq_detector_param #(.OVERLAP(1'b0)) u_d1 (.i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_in_valid(vld[1]), .i_in(in), .o_out(o_out[1]), .o_match_cnt(c1), .o_cnt_sat(sat[1]));
  seq_detector_param #(.PATTERN(4'b0000)) u_d2 (.i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_in_valid(vld[2]), .i_in(in), .o_out(o_out[2]), .o_match_cnt(c2), .o_cnt_sat(sat[2]));
  seq_detector_param #(.CNT_W(2)) u_d3 (.i_clk(clk), .i_rst_n(rst_n), .i_clear(clear),
    .i_in_valid(vld[3]), .i_in(in), .o_out(o_out[3]), .o_match_cnt(c3), .o_cnt_sat(sat[3]));

  function automatic int cnt_of(input int d);
    return d == 0 ? int'(c0) : d == 1 ? int'(c1) : d == 2 ? int'(c2) : int'(c3);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input int d, input bit b, input bit p, input int c);
    @(negedge clk);
    clear = 1'b0;
    vld = '0;
    vld[d] = 1'b1;
    in = b;
    if (p) sb.push_back('{d, cyc + 1, c});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vld = '0;
      clear = 1'b0;
    end
  endtask

  // clear arrives with valid high and a 1 on the input, which must be discarded
  task automatic do_clear();
    @(negedge clk);
    vld = '1;
    in = 1'b1;
    clear = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      checks++;
      failures++;
      $display("FAIL missed_pulse: dut %0d got no pulse expected pulse at cycle %0d", sb[0].d, sb[0].cyc);
      void'(sb.pop_front());
    end
    for (int d = 0; d < 4; d++) begin
      if (o_out[d]) begin
        checks++;
        if (sb.size() == 0 || sb[0].d != d || sb[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_pulse: dut %0d got pulse at cycle %0d expected none", d, cyc);
        end else begin
          chk($sformatf("pulse_cnt_dut%0d", d), cnt_of(d), sb[0].cnt);
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    logic [6:0]  s1;
    logic [15:0] s5;
    logic [3:0]  s6;
    s1 = 7'b1011011;
    s5 = 16'b1011011011011011;
    s6 = 4'b1011;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_out_dut%0d", d), int'(o_out[d]), 0);
      chk($sformatf("reset_cnt_dut%0d", d), cnt_of(d), 0);
      chk($sformatf("reset_sat_dut%0d", d), int'(sat[d]), 0);
    end
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 7; i++) send(0, s1[6-i], i == 3 || i == 6, i == 3 ? 1 : 2);
    for (int i = 0; i < 7; i++) send(1, s1[6-i], i == 3, 1);
    idle(2);
    chk("overlap_cnt", cnt_of(0), 2);
    chk("nonoverlap_cnt", cnt_of(1), 1);
    for (int i = 0; i < 5; i++) send(2, 1'b0, i >= 3, i - 2);
    idle(2);
    chk("zero_pattern_cnt", cnt_of(2), 2);
    do_clear();
    idle(1);
    for (int d = 0; d < 4; d++) chk($sformatf("clear_cnt_dut%0d", d), cnt_of(d), 0);
    for (int i = 0; i < 4; i++) begin
      send(0, s6[3-i], i == 3, 1);
      idle(3);
    end
    chk("gapped_cnt", cnt_of(0), 1);
    for (int i = 0; i < 16; i++) begin
      send(3, s5[15-i], i % 3 == 0 && i > 0, i < 9 ? i / 3 : 3);
      if (i == 6 || i == 9) begin
        idle(1);
        chk($sformatf("sat_after_bit%0d", i), int'(sat[3]), i == 9 ? 1 : 0);
      end
    end
    idle(2);
    chk("sat_cnt_held", cnt_of(3), 3);
    chk("sat_flag_held", int'(sat[3]), 1);
    do_clear();
    idle(1);
    chk("sat_clear_cnt", cnt_of(3), 0);
    chk("sat_clear_flag", int'(sat[3]), 0);
    for (int i = 0; i < 4; i++) send(0, s6[3-i], i == 3, 1);
    for (int i = 0; i < 3; i++) send(0, s6[3-i], 1'b0, 0);
    @(negedge clk);
    vld = '0;
    rst_n = 1'b0;
    #1;
    chk("midreset_cnt", cnt_of(0), 0);
    chk("midreset_out", int'(o_out[0]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(0, 1'b1, 1'b0, 0);
    for (int i = 1; i < 4; i++) send(0, s6[3-i], i == 3, 1);
    for (int i = 0; i < 4; i++) send(0, s6[3-i], i == 3, 2);
    idle(3);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
